// File: rtl/instr_pipe_if.sv
// Signal bundle between fetch/hazard logic and the D/E/M/W instruction-register bank.
// The master drives fetch and stall; the slave (the pipe) returns per-stage state.
interface instr_pipe_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            IR_F;
    logic [31:0]            PC_F;
    logic                   stall;

    logic [31:0]            IR_D;
    logic [31:0]            IR_E;
    logic [31:0]            IR_M;
    logic [31:0]            IR_W;
    logic [31:0]            PC8_D;
    logic [31:0]            PC8_E;
    logic [31:0]            PC8_M;
    logic [31:0]            PC8_W;
    logic [4:0]             A3_E;
    logic [4:0]             A3_M;
    logic [4:0]             A3_W;
    logic [1:0]             Tnew_E;
    logic [1:0]             Tnew_M;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output IR_F, PC_F, stall,
        input  IR_D, IR_E, IR_M, IR_W,
        input  PC8_D, PC8_E, PC8_M, PC8_W,
        input  A3_E, A3_M, A3_W, Tnew_E, Tnew_M, stall_cnt
    );

    modport slave (
        input  IR_F, PC_F, stall,
        output IR_D, IR_E, IR_M, IR_W,
        output PC8_D, PC8_E, PC8_M, PC8_W,
        output A3_E, A3_M, A3_W, Tnew_E, Tnew_M, stall_cnt
    );
endinterface

// File: rtl/instr_pipe.sv
// Pipeline instruction-register bank: carries IR, PC+8, destination GPR and Tnew
// from fetch through D/E/M/W, with stall (freeze D, bubble E) and a saturating stall counter.
module instr_pipe #(
    parameter int STALL_CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    instr_pipe_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_COP0  = 6'd16;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]            ir_d, ir_e, ir_m, ir_w;
    logic [31:0]            pc8_d, pc8_e, pc8_m, pc8_w;
    logic [4:0]             a3_e, a3_m, a3_w;
    logic [1:0]             tnew_e, tnew_m;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic [5:0]             d_op;
    logic [5:0]             d_fn;
    logic [4:0]             d_rs;
    logic [4:0]             d_rt;
    logic [4:0]             d_rd;
    logic                   d_is_mfc0;
    logic [4:0]             d_a3;
    logic [1:0]             d_tnew;
    logic [1:0]             e_tnew_dec;
    logic [31:0]            pc8_f;

    assign d_op      = ir_d[31:26];
    assign d_rs      = ir_d[25:21];
    assign d_rt      = ir_d[20:16];
    assign d_rd      = ir_d[15:11];
    assign d_fn      = ir_d[5:0];
    assign d_is_mfc0 = (d_op == OP_COP0) && (d_rs == 5'd0);

    // Wraps naturally mod 2^32.
    assign pc8_f = bus.PC_F + 32'd8;

    always_comb begin
        d_a3   = 5'd0;
        d_tnew = 2'd0;
        case (d_op)
            OP_RTYPE: begin
                if (d_fn != FN_JR) begin
                    d_a3   = d_rd;
                    d_tnew = 2'd1;
                end
            end
            OP_ANDI, OP_ORI, OP_LUI: begin
                d_a3   = d_rt;
                d_tnew = 2'd1;
            end
            OP_LW: begin
                d_a3   = d_rt;
                d_tnew = 2'd2;
            end
            OP_COP0: begin
                if (d_is_mfc0) begin
                    d_a3   = d_rt;
                    d_tnew = 2'd2;
                end
            end
            // JAL's link value already sits in PC8_E, so it is ready at once.
            OP_JAL: begin
                d_a3   = 5'd31;
                d_tnew = 2'd0;
            end
            default: begin
                d_a3   = 5'd0;
                d_tnew = 2'd0;
            end
        endcase
    end

    assign e_tnew_dec = (tnew_e == 2'd0) ? 2'd0 : (tnew_e - 2'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_d      <= 32'd0;
            pc8_d     <= 32'd0;
            ir_e      <= 32'd0;
            pc8_e     <= 32'd0;
            a3_e      <= 5'd0;
            tnew_e    <= 2'd0;
            ir_m      <= 32'd0;
            pc8_m     <= 32'd0;
            a3_m      <= 5'd0;
            tnew_m    <= 2'd0;
            ir_w      <= 32'd0;
            pc8_w     <= 32'd0;
            a3_w      <= 5'd0;
            stall_cnt <= '0;
        end else begin
            ir_w   <= ir_m;
            pc8_w  <= pc8_m;
            a3_w   <= a3_m;

            ir_m   <= ir_e;
            pc8_m  <= pc8_e;
            a3_m   <= a3_e;
            tnew_m <= e_tnew_dec;

            if (bus.stall) begin
                // Bubble into E is IR 0, the canonical sll $0 NOP.
                ir_e   <= 32'd0;
                pc8_e  <= 32'd0;
                a3_e   <= 5'd0;
                tnew_e <= 2'd0;
                if (stall_cnt != CNT_MAX) begin
                    stall_cnt <= stall_cnt + CNT_ONE;
                end
            end else begin
                ir_e   <= ir_d;
                pc8_e  <= pc8_d;
                a3_e   <= d_a3;
                tnew_e <= d_tnew;
                ir_d   <= bus.IR_F;
                pc8_d  <= pc8_f;
            end
        end
    end

    assign bus.IR_D      = ir_d;
    assign bus.IR_E      = ir_e;
    assign bus.IR_M      = ir_m;
    assign bus.IR_W      = ir_w;
    assign bus.PC8_D     = pc8_d;
    assign bus.PC8_E     = pc8_e;
    assign bus.PC8_M     = pc8_m;
    assign bus.PC8_W     = pc8_w;
    assign bus.A3_E      = a3_e;
    assign bus.A3_M      = a3_m;
    assign bus.A3_W      = a3_w;
    assign bus.Tnew_E    = tnew_e;
    assign bus.Tnew_M    = tnew_m;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_instr_pipe.sv
// Directed plus randomized bench for instr_pipe against an instruction-level reference model.
module tb_instr_pipe;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_pipe_if #(.STALL_CNT_W(16)) bus ();
    instr_pipe_if #(.STALL_CNT_W(2))  bus2 ();

    instr_pipe #(.STALL_CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    instr_pipe #(.STALL_CNT_W(2))  dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    assign bus2.IR_F  = bus.IR_F;
    assign bus2.PC_F  = bus.PC_F;
    assign bus2.stall = bus.stall;

    int passes = 0;
    int total  = 0;

    typedef enum int {K_RTYPE, K_JR, K_IMM, K_LOAD, K_MFC0, K_JAL, K_OTHER} kind_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [4:0]  a3;
        logic [1:0]  tnew;
    } slot_t;

    slot_t md, me, mm, mw;
    int    mcnt, mcnt2;

    function automatic kind_t classify(input logic [31:0] ir);
        int op, fn, rs;
        op = int'(ir[31:26]);
        fn = int'(ir[5:0]);
        rs = int'(ir[25:21]);
        if (op == 0) return (fn == 8) ? K_JR : K_RTYPE;
        if (op == 12 || op == 13 || op == 15) return K_IMM;
        if (op == 35) return K_LOAD;
        if (op == 16 && rs == 0) return K_MFC0;
        if (op == 3) return K_JAL;
        return K_OTHER;
    endfunction

    function automatic logic [4:0] ref_dest(input logic [31:0] ir);
        case (classify(ir))
            K_RTYPE:               return ir[15:11];
            K_IMM, K_LOAD, K_MFC0: return ir[20:16];
            K_JAL:                 return 5'd31;
            default:               return 5'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [31:0] ir);
        case (classify(ir))
            K_LOAD, K_MFC0: return 2;
            K_RTYPE, K_IMM: return 1;
            default:        return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_edge();
        slot_t nd, ne, nm, nw;
        if (!reset_n) begin
            nd = '{32'd0, 32'd0, 5'd0, 2'd0};
            md = nd; me = nd; mm = nd; mw = nd;
            mcnt = 0; mcnt2 = 0;
        end else begin
            nw = mm;
            nw.tnew = 2'd0;
            nm = me;
            nm.tnew = (me.tnew > 0) ? 2'(int'(me.tnew) - 1) : 2'd0;
            nd = md;
            if (bus.stall) begin
                ne = '{32'd0, 32'd0, 5'd0, 2'd0};
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end else begin
                ne.ir   = md.ir;
                ne.pc8  = md.pc8;
                ne.a3   = ref_dest(md.ir);
                ne.tnew = 2'(ref_latency(md.ir));
                nd.ir   = bus.IR_F;
                nd.pc8  = bus.PC_F + 32'd8;
            end
            md = nd; me = ne; mm = nm; mw = nw;
        end
    endtask

    task automatic check_model();
        check("IR_D",   bus.IR_D,   md.ir);
        check("PC8_D",  bus.PC8_D,  md.pc8);
        check("IR_E",   bus.IR_E,   me.ir);
        check("PC8_E",  bus.PC8_E,  me.pc8);
        check("A3_E",   32'(bus.A3_E),   32'(me.a3));
        check("Tnew_E", 32'(bus.Tnew_E), 32'(me.tnew));
        check("IR_M",   bus.IR_M,   mm.ir);
        check("PC8_M",  bus.PC8_M,  mm.pc8);
        check("A3_M",   32'(bus.A3_M),   32'(mm.a3));
        check("Tnew_M", 32'(bus.Tnew_M), 32'(mm.tnew));
        check("IR_W",   bus.IR_W,   mw.ir);
        check("PC8_W",  bus.PC8_W,  mw.pc8);
        check("A3_W",   32'(bus.A3_W),   32'(mw.a3));
        check("stall_cnt",   32'(bus.stall_cnt),  32'(mcnt));
        check("stall_cnt_w2", 32'(bus2.stall_cnt), 32'(mcnt2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: r[31:26] = 6'd0;
            1: begin r[31:26] = 6'd0; r[5:0] = 6'd8; end
            2: r[31:26] = 6'd12;
            3: r[31:26] = 6'd13;
            4: r[31:26] = 6'd15;
            5: r[31:26] = 6'd35;
            6: r[31:26] = 6'd3;
            7: begin r[31:26] = 6'd16; r[25:21] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd4; end
            8: r[31:26] = 6'd43;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        bus.IR_F  = 32'd0;
        bus.PC_F  = 32'd0;
        bus.stall = 1'b0;
        reset_n   = 1'b0;
        tick();
        tick();
        check("reset_IR_W", bus.IR_W, 32'd0);
        check("reset_cnt",  32'(bus.stall_cnt), 32'd0);

        reset_n   = 1'b1;
        bus.IR_F  = 32'h3401_0005;
        bus.PC_F  = 32'h0000_3000;
        tick();
        check("ori_IR_D",  bus.IR_D,  32'h3401_0005);
        check("ori_PC8_D", bus.PC8_D, 32'h0000_3008);

        bus.IR_F = 32'h8C22_0000;
        bus.PC_F = 32'h0000_3004;
        tick();
        check("ori_A3_E",   32'(bus.A3_E),   32'd1);
        check("ori_Tnew_E", 32'(bus.Tnew_E), 32'd1);

        bus.IR_F = 32'h0042_1821;
        bus.PC_F = 32'h0000_3008;
        tick();
        check("ori_Tnew_M", 32'(bus.Tnew_M), 32'd0);
        check("lw_A3_E",    32'(bus.A3_E),   32'd2);
        check("lw_Tnew_E",  32'(bus.Tnew_E), 32'd2);

        bus.IR_F  = 32'h3404_0007;
        bus.PC_F  = 32'h0000_300C;
        bus.stall = 1'b1;
        tick();
        check("stall_IR_D",   bus.IR_D, 32'h0042_1821);
        check("stall_IR_E",   bus.IR_E, 32'd0);
        check("stall_A3_E",   32'(bus.A3_E),   32'd0);
        check("stall_Tnew_E", 32'(bus.Tnew_E), 32'd0);
        check("stall_IR_M",   bus.IR_M, 32'h8C22_0000);
        check("lw_Tnew_M",    32'(bus.Tnew_M), 32'd1);
        check("ori_A3_W",     32'(bus.A3_W),   32'd1);
        check("stall_cnt1",   32'(bus.stall_cnt), 32'd1);

        bus.stall = 1'b0;
        tick();
        check("addu_IR_E", bus.IR_E, 32'h0042_1821);
        check("addu_A3_E", 32'(bus.A3_E), 32'd3);
        check("lw_A3_W",   32'(bus.A3_W), 32'd2);

        bus.IR_F = 32'h0C00_0004;
        bus.PC_F = 32'h0000_3010;
        tick();
        bus.IR_F = 32'h03E0_0008;
        bus.PC_F = 32'h0000_3014;
        tick();
        check("jal_A3_E",   32'(bus.A3_E),   32'd31);
        check("jal_Tnew_E", 32'(bus.Tnew_E), 32'd0);
        check("jal_PC8_E",  bus.PC8_E, 32'h0000_3018);

        bus.IR_F = 32'hAC22_0000;
        tick();
        check("jr_A3_E", 32'(bus.A3_E), 32'd0);
        bus.IR_F = 32'h4082_6000;
        tick();
        check("sw_A3_E", 32'(bus.A3_E), 32'd0);
        bus.IR_F = 32'h4003_6000;
        tick();
        check("mtc0_A3_E", 32'(bus.A3_E), 32'd0);
        bus.IR_F = 32'd0;
        bus.PC_F = 32'hFFFF_FFFC;
        tick();
        check("mfc0_A3_E",   32'(bus.A3_E),   32'd3);
        check("mfc0_Tnew_E", 32'(bus.Tnew_E), 32'd2);
        check("wrap_PC8_D",  bus.PC8_D, 32'h0000_0004);

        bus.IR_F  = 32'h3405_0001;
        tick();
        bus.stall = 1'b1;
        tick();
        reset_n   = 1'b0;
        tick();
        check("rst_IR_D",  bus.IR_D, 32'd0);
        check("rst_IR_M",  bus.IR_M, 32'd0);
        check("rst_PC8_W", bus.PC8_W, 32'd0);
        check("rst_cnt",   32'(bus.stall_cnt), 32'd0);

        reset_n   = 1'b1;
        bus.stall = 1'b0;
        bus.IR_F  = 32'h3406_0009;
        bus.PC_F  = 32'h0000_3020;
        tick();
        check("post_rst_IR_D", bus.IR_D, 32'h3406_0009);
        check("post_rst_IR_E", bus.IR_E, 32'd0);

        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt_w2", 32'(bus2.stall_cnt), 32'd3);
        check("cnt_w16",    32'(bus.stall_cnt),  32'd5);
        bus.stall = 1'b0;

        for (int i = 0; i < 400; i++) begin
            bus.IR_F  = rand_instr();
            bus.PC_F  = $urandom;
            bus.stall = ($urandom_range(0, 3) == 0);
            reset_n   = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
